// File: rtl/child_collect_pkg.sv
// Shared parameters and types for the child channel collector/arbiter.
package child_collect_pkg;

  localparam int NUM_CH_DEF = 5;
  localparam int ID_W       = 3;
  localparam int XCNT_W     = 16;

  typedef logic [ID_W-1:0] ch_idx_t;

endpackage

// File: rtl/child_collect_arb_rr_arbiter.sv
// Round-robin priority search: first requester strictly after last_grant, wrapping.
module rr_arbiter
  import child_collect_pkg::*;
#(
  parameter int N = NUM_CH_DEF
) (
  input  logic [N-1:0] req,
  input  ch_idx_t      last_grant,
  output logic [N-1:0] grant,
  output ch_idx_t      grant_idx
);

  // Walk N slots starting one past last_grant; the first hit wins.
  always_comb begin
    int   idx;
    logic found;
    logic hit;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    hit       = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(last_grant) + k;
      idx = (idx >= N) ? (idx - N) : idx;
      hit = req[idx] & ~found;
      grant[idx] = hit;
      grant_idx  = hit ? ch_idx_t'(idx) : grant_idx;
      found      = found | hit;
    end
  end

endmodule

// File: rtl/child_collect_arb.sv
// Merges NUM_CH child valid/ready channels onto one registered upstream port.
module child_collect_arb
  import child_collect_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [ID_W-1:0]          out_src,
  input  logic                     out_ready,
  output logic [XCNT_W-1:0]        xfer_cnt
);

  logic [NUM_CH-1:0] grant_s;
  ch_idx_t           grant_idx_s;
  logic              load_s;
  logic              in_fire_s;
  logic              unload_s;
  logic [DATA_W-1:0] sel_data_s;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  ch_idx_t           out_src_q, out_src_d;
  logic [XCNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  ch_idx_t           last_grant_q, last_grant_d;

  rr_arbiter #(
    .N (NUM_CH)
  ) u_rr (
    .req        (in_valid),
    .last_grant (last_grant_q),
    .grant      (grant_s),
    .grant_idx  (grant_idx_s)
  );

  // Handshake decode; in_ready is held low for the whole reset cycle.
  always_comb begin
    load_s    = ~out_valid_q | out_ready;
    in_ready  = grant_s & {NUM_CH{load_s & rst_n}};
    in_fire_s = |in_ready;
    unload_s  = out_valid_q & out_ready;
  end

  // Payload mux driven by the one-hot grant.
  always_comb begin
    sel_data_s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel_data_s = sel_data_s | (in_data[c*DATA_W +: DATA_W] & {DATA_W{grant_s[c]}});
    end
  end

  // Next state of the output stage and of the counter/pointer pair.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    xfer_cnt_d   = xfer_cnt_q + {{(XCNT_W-1){1'b0}}, unload_s};
    if (in_fire_s) begin
      out_valid_d  = 1'b1;
      out_data_d   = sel_data_s;
      out_src_d    = grant_idx_s;
      last_grant_d = grant_idx_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  // Transfer counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt_q   <= '0;
      last_grant_q <= ch_idx_t'(NUM_CH - 1);
    end else begin
      xfer_cnt_q   <= xfer_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_child_collect_arb.sv
// Directed bench for child_collect_arb with a queue-free behavioural reference model.
module tb_child_collect_arb;

  localparam int N  = 5;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_src;
  logic            out_ready;
  logic [15:0]     xfer_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  child_collect_arb #(.NUM_CH(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: state as the specification describes it.
  logic        m_ov   = 1'b0;
  logic [7:0]  m_data = 8'h00;
  int          m_src  = 0;
  int          m_lg   = N - 1;
  int          m_cnt  = 0;

  function automatic int pick(input logic [N-1:0] v, input int lg);
    for (int k = 1; k <= N; k++) begin
      if (v[(lg + k) % N]) return (lg + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    g = pick(in_valid, m_lg);
    if (!rst_n) begin
      m_ov <= 1'b0; m_data <= 8'h00; m_src <= 0; m_lg <= N - 1; m_cnt <= 0;
    end else begin
      if (m_ov && out_ready) m_cnt <= (m_cnt + 1) % 65536;
      if ((!m_ov || out_ready) && g >= 0) begin
        m_ov <= 1'b1; m_data <= in_data[g*DW +: DW]; m_src <= g; m_lg <= g;
      end else if (out_ready) begin
        m_ov <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_rdy;
    g = pick(in_valid, m_lg);
    exp_rdy = '0;
    if (rst_n && (!m_ov || out_ready) && g >= 0) exp_rdy[g] = 1'b1;
    chk("mdl_in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("mdl_out_valid", 32'(out_valid), 32'(m_ov));
    chk("mdl_out_data", 32'(out_data), 32'(m_data));
    chk("mdl_out_src", 32'(out_src), 32'(m_src));
    chk("mdl_xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0;
    tick();
    rst_n = 1'b1;
  endtask

  int rr_exp[6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    rst_n = 1'b0;
    in_valid = 5'b11111;
    out_ready = 1'b1;
    for (int c = 0; c < N; c++) in_data[c*DW +: DW] = 8'(8'h10 + c);
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
    rst_n = 1'b1;
    in_valid = '0;
    tick();

    // Single request on channel 2
    in_valid = 5'b00100;
    in_data[2*DW +: DW] = 8'hA5;
    #1 chk("single_in_ready", 32'(in_ready), 32'h04);
    tick();
    in_valid = '0;
    chk("single_out_valid", 32'(out_valid), 32'h1);
    chk("single_out_data", 32'(out_data), 32'hA5);
    chk("single_out_src", 32'(out_src), 32'h2);
    chk("single_cnt_before", 32'(xfer_cnt), 32'h0);
    tick();
    chk("single_cnt_after", 32'(xfer_cnt), 32'h1);
    chk("single_drain", 32'(out_valid), 32'h0);

    // Round-robin over all channels, no bubbles
    do_reset();
    in_valid = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rr_src", 32'(out_src), 32'(rr_exp[i]));
      chk("rr_valid", 32'(out_valid), 32'h1);
    end

    // Backpressure while holding src 1
    in_valid = 5'b00010;
    tick();
    chk("bp_load_src1", 32'(out_src), 32'h1);
    out_ready = 1'b0;
    in_valid = 5'b11000;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_src", 32'(out_src), 32'h1);
      chk("bp_data", 32'(out_data), 32'h11);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_rel_src3", 32'(out_src), 32'h3);
    chk("bp_rel_data3", 32'(out_data), 32'h13);
    tick();
    chk("bp_rel_src4", 32'(out_src), 32'h4);
    in_valid = '0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'h0);

    // Withdrawn request on channel 1
    do_reset();
    in_valid = 5'b00001;
    tick();
    chk("wd_src0", 32'(out_src), 32'h0);
    out_ready = 1'b0;
    in_valid = 5'b00110;
    #1 chk("wd_blocked", 32'(in_ready), 32'h0);
    tick();
    in_valid = 5'b00100;
    tick();
    out_ready = 1'b1;
    #1 chk("wd_grant2", 32'(in_ready), 32'h04);
    tick();
    chk("wd_src2", 32'(out_src), 32'h2);
    in_valid = 5'b01010;
    #1 chk("wd_next_is_3", 32'(in_ready), 32'h08);
    tick();
    chk("wd_src3", 32'(out_src), 32'h3);
    in_valid = '0;
    tick();

    // Reset in the middle of a stream
    in_valid = 5'b11111;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1 chk("mid_rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_cnt", 32'(xfer_cnt), 32'h0);
    rst_n = 1'b1;
    in_valid = 5'b10110;
    #1 chk("post_rst_grant", 32'(in_ready), 32'h02);
    tick();
    chk("post_rst_src", 32'(out_src), 32'h1);
    in_valid = '0;
    tick();

    // Counter wrap
    do_reset();
    in_valid = 5'b00001;
    out_ready = 1'b1;
    repeat (65536) tick();
    chk("cnt_ffff", 32'(xfer_cnt), 32'hFFFF);
    tick();
    chk("cnt_wrap", 32'(xfer_cnt), 32'h0);
    in_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
